// File: rtl/icache_pkg.sv
// Shared constants and address-field helpers for the direct-mapped instruction cache.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icache_pkg;

    // Default geometry; the top-level parameters take these as defaults.
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_LINES  = 64;
    localparam int OFF_W          = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W          = $clog2(DEF_NUM_LINES);
    localparam int TAG_W          = 30 - OFF_W - IDX_W;

    // Controller states, kept as plain constants for compatibility with older tools.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] INVAL  = 2'd2;

    // Tag field, right-justified; caller keeps the low tag_w bits.
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
        return a >> (off_w + idx_w + 2);
    endfunction

    // Line index field, right-justified and masked.
    function automatic logic [31:0] addr_idx(input logic [31:0] a, input int off_w, input int idx_w);
        return (a >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Word-within-line field, right-justified and masked.
    function automatic logic [31:0] addr_word(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    // Line-aligned byte address of the line holding a.
    function automatic logic [31:0] addr_base(input logic [31:0] a, input int off_w);
        return a & ~((32'd1 << (off_w + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, one synchronous write port, bulk valid clear.
// Latency: reads are zero-cycle; writes land at the next CLK edge.
// Backpressure: none; the controller owns all sequencing.
module icache_array #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 6,
    parameter int OFF_W      = 2,
    parameter int TAG_W      = 22
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_word,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic             fill_done,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             clr_all
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES*LINE_WORDS];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[{rd_idx, rd_word}];

    // Valid bits: only these are reset; bulk clear wins over a line completing.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are plain storage with no reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data[{wr_idx, wr_word}] <= wr_data;
        end
        if (fill_done) begin
            tags[wr_idx] <= fill_tag;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill on miss.
// Latency: hit returns the word in the same cycle; miss costs LINE_WORDS acks plus two lookup cycles.
// Backpressure: fetch_stall holds fetch while not hitting; mem_req/mem_addr stay stable until mem_ack.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_instr,
    output logic        fetch_stall,
    input  logic        inv_all,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 30 - OW - IW;
    localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);
    localparam logic [OW-1:0] ONE_WORD  = OW'(1);

    logic [31:0]   tag_full, idx_full, word_full, base_full;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [OW-1:0] req_word;
    logic          unused_bits;

    logic [1:0]    state;
    logic [OW-1:0] cnt;
    logic          inv_pend;
    logic [31:0]   base;
    logic [IW-1:0] ref_idx;
    logic [TW-1:0] ref_tag;

    logic          line_valid;
    logic [TW-1:0] line_tag;
    logic [31:0]   line_data;
    logic          hit;
    logic          beat;
    logic          last_beat;
    logic          clr_all;

    assign tag_full  = addr_tag(fetch_addr, OW, IW);
    assign idx_full  = addr_idx(fetch_addr, OW, IW);
    assign word_full = addr_word(fetch_addr, OW);
    assign base_full = addr_base(fetch_addr, OW);
    assign req_tag   = tag_full[TW-1:0];
    assign req_idx   = idx_full[IW-1:0];
    assign req_word  = word_full[OW-1:0];
    // Upper bits of the helper results are zero by construction; byte offset is ignored.
    assign unused_bits = ^{tag_full[31:TW], idx_full[31:IW], word_full[31:OW], fetch_addr[1:0]};

    // Lookups are only trusted in IDLE with no invalidate pending, so a refill never
    // exposes a half-written line.
    assign hit         = line_valid && (line_tag == req_tag) && (state == IDLE) && !inv_pend;
    assign fetch_stall = !hit;
    assign fetch_instr = hit ? line_data : 32'h0;

    // mem_ack outside REFILL is not a beat.
    assign beat      = (state == REFILL) && mem_ack;
    assign last_beat = beat && (cnt == LAST_WORD);
    assign mem_req   = (state == REFILL);
    assign mem_addr  = (state == REFILL) ? (base + {{(30-OW){1'b0}}, cnt, 2'b00}) : 32'h0;

    // Invalidate in IDLE takes effect at once; INVAL replays an invalidate deferred by a refill.
    assign clr_all = ((state == IDLE) && inv_all) || (state == INVAL);

    icache_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_WORDS(LINE_WORDS),
        .IDX_W     (IW),
        .OFF_W     (OW),
        .TAG_W     (TW)
    ) u_array (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_idx   (req_idx),
        .rd_word  (req_word),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (beat),
        .wr_idx   (ref_idx),
        .wr_word  (cnt),
        .wr_data  (mem_data),
        .fill_done(last_beat),
        .fill_tag (ref_tag),
        .clr_all  (clr_all)
    );

    // Refill controller: latch the missing line, count beats, then return to lookup.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            inv_pend <= 1'b0;
            base     <= 32'h0;
            ref_idx  <= '0;
            ref_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        base    <= base_full;
                        ref_idx <= req_idx;
                        ref_tag <= req_tag;
                        cnt     <= '0;
                        state   <= REFILL;
                    end
                end
                REFILL: begin
                    if (inv_all) begin
                        inv_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        cnt <= cnt + ONE_WORD;
                        if (cnt == LAST_WORD) begin
                            cnt   <= '0;
                            // An invalidate arriving on the final beat must not be lost.
                            state <= (inv_pend || inv_all) ? INVAL : IDLE;
                        end
                    end
                end
                INVAL: begin
                    inv_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a combinational memory model.
// Latency: n/a.
// Backpressure: memory ack pattern is chosen per test.
module tb_icache_dm;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        fetch_stall;
    logic        inv_all;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;
    int s;

    icache_dm dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .fetch_addr (fetch_addr),
        .fetch_instr(fetch_instr),
        .fetch_stall(fetch_stall),
        .inv_all    (inv_all),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign mem_data = mem_ack ? mem_word(mem_addr) : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; inputs are then changed well away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Fetch address a until it hits. Memory acks every period-th REFILL cycle.
    // Every REFILL cycle checks mem_addr against the expected beat address.
    task automatic run_fill(input logic [31:0] a, input int period, output int stalls);
        int beats;
        int rcyc;
        logic [31:0] lbase;
        lbase = a & ~32'hF;
        beats = 0;
        rcyc = 0;
        stalls = 0;
        fetch_addr = a;
        for (int c = 0; c < 200; c++) begin
            mem_ack = mem_req && ((rcyc % period) == period - 1);
            #1;
            if (!fetch_stall) break;
            stalls++;
            if (mem_req) begin
                check("fill_mem_addr", mem_addr, lbase + 32'(4 * beats));
                if (mem_ack) beats++;
                rcyc++;
            end
            tick();
        end
        mem_ack = 1'b0;
        #1;
        check("fill_done_stall", {31'h0, fetch_stall}, 32'h0);
        check("fill_hit_word", fetch_instr, mem_word(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        fetch_addr = 32'h0;
        inv_all = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        // Reset state.
        check("rst_stall", {31'h0, fetch_stall}, 32'h1);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr", fetch_instr, 32'h0);
        RESET = 1'b1;

        // Cold start: five stalled cycles then the refilled word.
        run_fill(32'hBFC0_0000, 1, s);
        check("cold_stalls", 32'(s), 32'd5);
        fetch_addr = 32'hBFC0_0004;
        #1;
        check("cold_next_stall", {31'h0, fetch_stall}, 32'h0);
        check("cold_next_word", fetch_instr, mem_word(32'hBFC0_0004));
        tick();

        // Conflict on idx 0: the new tag refills, then the old one misses again.
        run_fill(32'hBFC0_0400, 1, s);
        check("conflict_stalls", 32'(s), 32'd5);
        run_fill(32'hBFC0_0000, 1, s);
        check("conflict_back_stalls", 32'(s), 32'd5);
        tick();

        // Slow memory: ack every third cycle, 1 lookup + 4*3 refill cycles.
        run_fill(32'hBFC0_0034, 3, s);
        check("slow_stalls", 32'(s), 32'd13);
        tick();

        // Last line, last word: addresses stay inside the line.
        run_fill(32'hBFC0_03FC, 1, s);
        check("last_line_stalls", 32'(s), 32'd5);
        fetch_addr = 32'hBFC0_03F0;
        #1;
        check("last_line_w0", fetch_instr, mem_word(32'hBFC0_03F0));
        tick();

        // Invalidate mid-refill: line completes, INVAL cycle, then still misses.
        fetch_addr = 32'hBFC0_0010;
        #1;
        check("inv_miss", {31'h0, fetch_stall}, 32'h1);
        tick();
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b1;
            inv_all = (b == 1);
            #1;
            check("inv_mem_addr", mem_addr, 32'hBFC0_0010 + 32'(4 * b));
            tick();
        end
        mem_ack = 1'b0;
        inv_all = 1'b0;
        #1;
        check("inv_cycle_stall", {31'h0, fetch_stall}, 32'h1);
        check("inv_cycle_req", {31'h0, mem_req}, 32'h0);
        tick();
        check("inv_after_stall", {31'h0, fetch_stall}, 32'h1);
        check("inv_after_req", {31'h0, mem_req}, 32'h0);
        run_fill(32'hBFC0_0010, 1, s);
        check("inv_refill_stalls", 32'(s), 32'd5);

        // Invalidate in IDLE: same cycle still hits, next cycle misses.
        inv_all = 1'b1;
        #1;
        check("inv_idle_same", {31'h0, fetch_stall}, 32'h0);
        tick();
        inv_all = 1'b0;
        #1;
        check("inv_idle_next", {31'h0, fetch_stall}, 32'h1);
        run_fill(32'hBFC0_0010, 1, s);
        tick();

        // Redirect during refill: old line completes, then the new address refills.
        fetch_addr = 32'hBFC0_0020;
        mem_ack = 1'b0;
        #1;
        check("redir_miss", {31'h0, fetch_stall}, 32'h1);
        tick();
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b1;
            if (b == 2) fetch_addr = 32'h8000_1000;
            #1;
            check("redir_mem_addr", mem_addr, 32'hBFC0_0020 + 32'(4 * b));
            tick();
        end
        mem_ack = 1'b0;
        #1;
        check("redir_lookup_stall", {31'h0, fetch_stall}, 32'h1);
        tick();
        check("redir_new_addr", mem_addr, 32'h8000_1000);
        run_fill(32'h8000_1000, 1, s);
        fetch_addr = 32'hBFC0_0020;
        #1;
        check("redir_old_hit", {31'h0, fetch_stall}, 32'h0);
        check("redir_old_word", fetch_instr, mem_word(32'hBFC0_0020));
        tick();

        // Reset after two beats of a refill: request drops at once, lines invalid after.
        fetch_addr = 32'hBFC0_0000;
        #1;
        check("rstmid_miss", {31'h0, fetch_stall}, 32'h1);
        tick();
        mem_ack = 1'b1;
        tick();
        tick();
        #1;
        check("rstmid_req_before", {31'h0, mem_req}, 32'h1);
        RESET = 1'b0;
        #1;
        check("rstmid_req_drop", {31'h0, mem_req}, 32'h0);
        check("rstmid_addr_zero", mem_addr, 32'h0);
        tick();
        mem_ack = 1'b0;
        RESET = 1'b1;
        #1;
        check("rstmid_miss_after", {31'h0, fetch_stall}, 32'h1);
        fetch_addr = 32'hBFC0_0010;
        #1;
        check("rstmid_other_miss", {31'h0, fetch_stall}, 32'h1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and instruction memory.
- Fetch presents a PC every cycle and samples the returned instruction in the same cycle.
- On a hit the word is returned combinationally.
- On a miss the cache stalls fetch, refills the whole line from the memory port one word per handshake, then resumes.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, >=2.
- NUM_LINES, 64, number of lines; power of two.
- Derived values: OFF_W=log2(LINE_WORDS), IDX_W=log2(NUM_LINES), TAG_W=30-OFF_W-IDX_W.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- fetch_addr  in  32  PC from fetch; bits[1:0] ignored.
- fetch_instr  out  32  instruction at fetch_addr; valid only when fetch_stall=0.
- fetch_stall  out  1  high while the word is unavailable; ORed into fetch STALL.
- inv_all  in  1  one-cycle pulse that invalidates every line (issued on SYS/cache-op).
- mem_req  out  1  refill request valid.
- mem_addr  out  32  word-aligned refill address.
- mem_ack  in  1  mem_data valid for the current mem_addr this cycle.
- mem_data  in  32  refill word.

Behaviour:
- Address split:
  - tag = fetch_addr[31:32-TAG_W]
  - idx = fetch_addr[OFF_W+IDX_W+1:OFF_W+2]
  - word = fetch_addr[OFF_W+1:2]
- Storage: valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES*LINE_WORDS].
  - Read is asynchronous (combinational).
  - Write is synchronous.
- Reset (async, RESET=0):
  - state=IDLE, all valid=0, cnt=0, inv_pend=0.
  - mem_req=0, mem_addr=0, fetch_stall=1 (combinational from miss), fetch_instr=0.
  - Data/tag arrays are not cleared.
- hit = valid[idx] && tag[idx]==tag && state==IDLE && !inv_pend.
- fetch_instr = hit ? data[idx][word] : 32'h0.
- fetch_stall = !hit.
- FSM states IDLE, REFILL, INVAL:
  - IDLE, hit: no state change, zero latency.
  - IDLE, miss:
    - latch base = {fetch_addr[31:OFF_W+2], 0...} and idx.
    - cnt=0, go REFILL next edge.
  - REFILL:
    - mem_req=1, mem_addr = base + 4*cnt.
    - On mem_ack: write data[idx][cnt]=mem_data, cnt++.
    - On mem_ack with cnt==LINE_WORDS-1: write tag, set valid, go INVAL if inv_pend else IDLE.
    - Without mem_ack: hold mem_req and mem_addr stable.
  - INVAL: clear all valid, clear inv_pend, go IDLE. Costs one stalled cycle.
- Miss penalty: 1 lookup cycle + LINE_WORDS acks + 1 re-lookup cycle.
  - With single-cycle ack: LINE_WORDS+1 stalled cycles, hit on cycle LINE_WORDS+2.
- Simultaneous and boundary events:
  - fetch_addr changes during REFILL (redirect): refill runs to completion, no abort; the new address is looked up in IDLE afterwards.
  - inv_all in IDLE: all valid cleared at the edge. The same cycle's lookup may still hit (old contents); the next cycle misses.
  - inv_all in REFILL: sets inv_pend. The line completes and is then cleared via INVAL. Never leave a stale valid line.
  - inv_all in INVAL: absorbed.
  - Conflict miss to a valid line: overwrite; no writeback (read-only cache).
  - Last line (idx=NUM_LINES-1) and last word: no wrap into the next line; base never increments past the line.
  - mem_ack while mem_req=0: ignored.
  - RESET asserted mid-REFILL: immediate IDLE, mem_req drops asynchronously, partial line stays invalid.
  - Memory may hold mem_ack for consecutive cycles; each asserted cycle is one beat.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, REFILL, INVAL}
  - derived width constants OFF_W, IDX_W, TAG_W
  - address-field extraction functions
- One sub-module, icache_array: valid/tag/data storage with combinational read, single write port, and bulk valid clear.
- FSM and counter live in icache_dm.

Test Plan:
- Cold start: reset then fetch_addr=0xBFC00000 with ack each cycle.
  - Required: mem_addr 0xBFC00000, 04, 08, 0C on consecutive cycles.
  - fetch_stall=1 for 5 cycles; then hit returns the word provided for 0xBFC00000.
  - 0xBFC00004 hits immediately.
- Conflict: fill 0xBFC00000, then fetch 0xBFC00400 (same idx 0, different tag).
  - Required: refill from 0xBFC00400.
  - Re-fetch of 0xBFC00000 misses again.
- Slow memory: mem_ack only every 3rd cycle.
  - Required: mem_addr held stable between acks.
  - fetch_stall stays high until 1 cycle after the 4th ack.
- Invalidate: inv_all pulsed mid-refill of 0xBFC00010.
  - Required: refill completes, INVAL cycle occurs.
  - Next fetch of 0xBFC00010 misses.
  - inv_all in IDLE makes a previously hitting line miss the next cycle.
- Redirect: fetch_addr switches to 0x80001000 during refill of 0xBFC00020.
  - Required: 0xBFC00020 line completes and becomes valid.
  - Refill of 0x80001000 follows.
- Reset mid-refill after 2 acks: mem_req=0 immediately; afterwards 0xBFC00000 misses.
